bus_rr_scheduler: RTL and testbench

Round-robin scheduler for the shared packet bus connecting `drvrs` device FIFOs. It watches every device's `pndng` flag and grants the bus to one device at a time in fair rotation. It pops the granted device's head packet, decodes the 8-bit destination in the packet header, and pushes the packet to the destination device, or to all other devices on broadcast. It is the sequencing core of the bus generator/arbiter and sits between the device-side FIFO interface (`pndng`/`pop`/`D_pop`) and the delivery interface (`push`/`D_push`).

---
 rtl/bus_rr_scheduler.sv | 149 ++++++++++++++
 tb/tb_bus_rr_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler for the shared packet bus: grants one pending device at a time,
// pops its head packet and pushes it to the addressed device or broadcasts it.
module bus_rr_scheduler #(
    parameter int unsigned pckg_sz   = 24,
    parameter int unsigned drvrs     = 16,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [drvrs-1:0]           pndng,
    input  logic [drvrs*pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]           pop,
    output logic [drvrs-1:0]           push,
    output logic [pckg_sz-1:0]         D_push,
    output logic [$clog2(drvrs)-1:0]   grant_id,
    output logic                       busy,
    output logic [15:0]                pkt_cnt,
    output logic [15:0]                drop_cnt
);

    localparam int unsigned GW = $clog2(drvrs);
    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        PUSH  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [drvrs-1:0]    pop_q, pop_d;
    logic [drvrs-1:0]    push_q, push_d;
    logic [pckg_sz-1:0]  d_push_q, d_push_d;
    logic [GW-1:0]       grant_id_q, grant_id_d;
    logic [GW-1:0]       last_grant_q, last_grant_d;
    logic                busy_q, busy_d;
    logic [CW-1:0]       pkt_cnt_q, pkt_cnt_d;
    logic [CW-1:0]       drop_cnt_q, drop_cnt_d;

    logic [pckg_sz-1:0]  head [drvrs];
    logic [pckg_sz-1:0]  pkt;
    logic [7:0]          dest;
    logic [GW-1:0]       sel;
    logic [GW-1:0]       cand;
    logic                found;

    // Per-device view of the flattened head-packet bus
    for (genvar i = 0; i < drvrs; i++) begin : g_head
        assign head[i] = D_pop[i*pckg_sz +: pckg_sz];
    end

    always_comb begin
        state_d      = state_q;
        pop_d        = pop_q;
        push_d       = push_q;
        d_push_d     = d_push_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        busy_d       = busy_q;
        pkt_cnt_d    = pkt_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        sel          = '0;
        cand         = '0;
        found        = 1'b0;
        pkt          = head[grant_id_q];
        dest         = pkt[pckg_sz-1 -: 8];

        // First pending device searching upward from the one after last_grant
        for (int unsigned k = 1; k <= drvrs; k++) begin
            cand = GW'((32'(last_grant_q) + k) % drvrs);
            if (!found && pndng[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_id_d = sel;
                    pop_d      = '0;
                    pop_d[sel] = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                pop_d    = '0;
                d_push_d = pkt;
                push_d   = '0;
                if (32'(dest) < drvrs) begin
                    push_d[GW'(dest)] = 1'b1;
                end else if (dest == broadcast) begin
                    push_d             = '1;
                    push_d[grant_id_q] = 1'b0;
                end else begin
                    drop_cnt_d = drop_cnt_q + CW'(1);
                end
                state_d = PUSH;
            end
            PUSH: begin
                push_d       = '0;
                last_grant_d = grant_id_q;
                busy_d       = 1'b0;
                if (push_q != '0) begin
                    pkt_cnt_d = pkt_cnt_q + CW'(1);
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset parks last_grant on the top device so the first grant favours device 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pop_q        <= '0;
            push_q       <= '0;
            d_push_q     <= '0;
            grant_id_q   <= GW'(drvrs - 1);
            last_grant_q <= GW'(drvrs - 1);
            busy_q       <= 1'b0;
            pkt_cnt_q    <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pop_q        <= pop_d;
            push_q       <= push_d;
            d_push_q     <= d_push_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            pkt_cnt_q    <= pkt_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign D_push   = d_push_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Bench for bus_rr_scheduler: directed scenarios plus random traffic checked against
// a transaction-level model of the rotation, decode and counters.
module tb_bus_rr_scheduler;

    localparam int unsigned N = 16;
    localparam int unsigned W = 24;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   pndng = '0;
    logic [N*W-1:0] d_pop = '0;
    logic [N-1:0]   pop;
    logic [N-1:0]   push;
    logic [W-1:0]   d_push;
    logic [3:0]     grant_id;
    logic           busy;
    logic [15:0]    pkt_cnt;
    logic [15:0]    drop_cnt;

    logic [W-1:0]   head [N];
    int             m_last;
    logic [15:0]    m_pkt;
    logic [15:0]    m_drop;
    int             grants_seen [N];
    int             n_checks = 0;
    int             n_errors = 0;

    bus_rr_scheduler #(.pckg_sz(W), .drvrs(N), .broadcast(8'hFF)) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (d_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (d_push),
        .grant_id (grant_id),
        .busy     (busy),
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] p);
        pndng = p;
        for (int i = 0; i < N; i++) d_pop[i*W +: W] = head[i];
    endtask

    task automatic model_reset();
        m_last = N - 1;
        m_pkt  = '0;
        m_drop = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // Lowest pending index above the last grant, else the lowest pending index overall
    function automatic int pick(input logic [N-1:0] p, input int last);
        int lowest = -1;
        int above  = -1;
        for (int i = 0; i < N; i++) begin
            if (p[i]) begin
                if (lowest < 0) lowest = i;
                if (above < 0 && i > last) above = i;
            end
        end
        return (above >= 0) ? above : lowest;
    endfunction

    function automatic logic [N-1:0] exp_push(input logic [7:0] dest, input int src);
        if (dest < 8'(N)) return 16'(1) << dest;
        if (dest == 8'hFF) return ~(16'(1) << src);
        return '0;
    endfunction

    task automatic txn(input logic [N-1:0] p, input bit scramble);
        int           g;
        logic [W-1:0] pk;
        logic [N-1:0] ep;
        drive(p);
        tick();
        if (p == '0) begin
            check("idle_pop", 32'(pop), 32'(0));
            check("idle_busy", 32'(busy), 32'(0));
            return;
        end
        g  = pick(p, m_last);
        pk = head[g];
        ep = exp_push(pk[W-1 -: 8], g);
        check("grant_pop", 32'(pop), 32'(16'(1) << g));
        check("grant_id", 32'(grant_id), 32'(g));
        check("grant_busy", 32'(busy), 32'(1));
        check("grant_push", 32'(push), 32'(0));
        grants_seen[g]++;
        if (scramble) drive(16'($urandom));
        tick();
        if (ep == '0) m_drop++;
        check("push_pop", 32'(pop), 32'(0));
        check("push_mask", 32'(push), 32'(ep));
        check("push_data", 32'(d_push), 32'(pk));
        check("push_busy", 32'(busy), 32'(1));
        check("push_drop", 32'(drop_cnt), 32'(m_drop));
        tick();
        if (ep != '0) m_pkt++;
        m_last = g;
        check("done_push", 32'(push), 32'(0));
        check("done_busy", 32'(busy), 32'(0));
        check("done_pkt", 32'(pkt_cnt), 32'(m_pkt));
        check("done_data", 32'(d_push), 32'(pk));
    endtask

    task automatic rand_heads();
        logic [7:0] dest;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 9))
                0:       dest = 8'hFF;
                1:       dest = 8'($urandom_range(16, 254));
                default: dest = 8'($urandom_range(0, 15));
            endcase
            head[i] = {dest, 16'($urandom)};
        end
    endtask

    initial begin
        logic [N-1:0] rp;
        for (int i = 0; i < N; i++) begin
            head[i] = '0;
            grants_seen[i] = 0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_pop", 32'(pop), 32'(0));
        check("rst_push", 32'(push), 32'(0));
        check("rst_data", 32'(d_push), 32'(0));
        check("rst_grant", 32'(grant_id), 32'(15));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_pkt", 32'(pkt_cnt), 32'(0));
        check("rst_drop", 32'(drop_cnt), 32'(0));
        reset = 1'b1;

        // Single requester
        head[2] = 24'h05_ABCD;
        txn(16'h0004, 1'b0);
        check("single_grant", 32'(grant_id), 32'(2));
        check("single_pkt", 32'(pkt_cnt), 32'(1));

        // Fairness: everyone pending, all addressed to device 0
        do_reset();
        for (int i = 0; i < N; i++) begin
            head[i] = {8'h00, 16'($urandom)};
            grants_seen[i] = 0;
        end
        repeat (48) txn(16'hFFFF, 1'b0);
        for (int i = 0; i < N; i++) check("fair_share", 32'(grants_seen[i]), 32'(3));
        check("fair_pkt", 32'(pkt_cnt), 32'(48));

        // Broadcast from device 7
        head[7] = 24'hFF_1234;
        txn(16'h0080, 1'b0);
        check("bcast_pkt", 32'(pkt_cnt), 32'(49));

        // Invalid destination, immediately followed by another grant
        head[3] = 24'h20_0000;
        txn(16'h0008, 1'b0);
        check("drop_cnt", 32'(drop_cnt), 32'(1));
        check("drop_pkt", 32'(pkt_cnt), 32'(49));
        head[5] = 24'h01_5555;
        txn(16'h0020, 1'b0);

        // Wrap-around in both directions
        do_reset();
        head[0]  = 24'h01_0000;
        head[15] = 24'h02_000F;
        txn(16'h8001, 1'b0);
        check("wrap_lo", 32'(grant_id), 32'(0));
        txn(16'h8001, 1'b0);
        check("wrap_hi", 32'(grant_id), 32'(15));

        // Random traffic, pending flags disturbed while a grant is committed
        for (int t = 0; t < 400; t++) begin
            rand_heads();
            case ($urandom_range(0, 3))
                0:       rp = '0;
                1:       rp = 16'hFFFF;
                default: rp = 16'($urandom) & 16'($urandom);
            endcase
            txn(rp, 1'($urandom));
        end

        // Reset asserted in the middle of a PUSH cycle
        head[4] = 24'h02_BEEF;
        drive(16'h0010);
        tick();
        tick();
        check("mid_push_live", 32'(push), 32'(16'h0004));
        #3;
        reset = 1'b0;
        #1;
        check("mid_push", 32'(push), 32'(0));
        check("mid_pop", 32'(pop), 32'(0));
        check("mid_busy", 32'(busy), 32'(0));
        check("mid_pkt", 32'(pkt_cnt), 32'(0));
        check("mid_drop", 32'(drop_cnt), 32'(0));
        check("mid_grant", 32'(grant_id), 32'(15));
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < N; i++) head[i] = {8'($urandom_range(0, 15)), 16'($urandom)};
        txn(16'hFFFF, 1'b0);
        check("post_rst_grant", 32'(grant_id), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
